// File: rtl/uart_rx_ctrl_if.sv
// Receive controller bus: receiver-side character strobes and APB-side FIFO/status access.
interface uart_rx_ctrl_if #(
    parameter int unsigned AW = 4
);
    logic          baud_tick;
    logic          rx_en;
    logic          rx_done;
    logic [7:0]    rx_data;
    logic          parity_error;
    logic          rd_en;
    logic          flush;
    logic          clr_overrun;
    logic [AW:0]   thresh;
    logic [2:0]    irq_en;
    logic [7:0]    rd_data;
    logic          rd_perr;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overrun;
    logic          irq_timeout;
    logic          irq;

    modport master (
        output baud_tick, rx_en, rx_done, rx_data, parity_error,
        output rd_en, flush, clr_overrun, thresh, irq_en,
        input  rd_data, rd_perr, empty, full, count, overrun, irq_timeout, irq
    );

    modport slave (
        input  baud_tick, rx_en, rx_done, rx_data, parity_error,
        input  rd_en, flush, clr_overrun, thresh, irq_en,
        output rd_data, rd_perr, empty, full, count, overrun, irq_timeout, irq
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: FWFT character FIFO with parity flags, overrun tracking,
// baud-tick idle timeout and a registered maskable interrupt.
module uart_rx_ctrl #(
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned AW            = 4,
    parameter int unsigned TIMEOUT_TICKS = 40
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_rx_ctrl_if.slave  bus
);
    localparam int unsigned DW = 9;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = 16;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_COUNT = 2'd1,
        T_FIRED = 2'd2
    } state_e;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          irq_timeout_q, irq_timeout_d;
    logic          irq_q, irq_d;
    state_e        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;

    logic          empty_c, full_c, pop_c, push_c, drop_c, act_c, thr_hit_c;
    logic [DW-1:0] head_c;

    // Status and per-cycle FIFO operations; flush overrides push and pop
    assign empty_c   = (count_q == '0);
    assign full_c    = (count_q == CW'(DEPTH));
    assign pop_c     = bus.rd_en & ~empty_c & ~bus.flush;
    assign push_c    = bus.rx_done & bus.rx_en & (~full_c | (bus.rd_en & ~empty_c)) & ~bus.flush;
    assign drop_c    = bus.rx_done & bus.rx_en & full_c & ~bus.rd_en & ~bus.flush;
    assign act_c     = push_c | pop_c | bus.flush;
    assign thr_hit_c = (bus.thresh != '0) & (count_q >= bus.thresh);
    assign head_c    = mem_q[rd_ptr_q];

    assign bus.rd_data     = empty_c ? 8'h00 : head_c[7:0];
    assign bus.rd_perr     = empty_c ? 1'b0  : head_c[8];
    assign bus.empty       = empty_c;
    assign bus.full        = full_c;
    assign bus.count       = count_q;
    assign bus.overrun     = overrun_q;
    assign bus.irq_timeout = irq_timeout_q;
    assign bus.irq         = irq_q;

    // Pointer, occupancy and overrun next state
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push_c && !pop_c)      count_d = count_q + CW'(1);
            else if (pop_c && !push_c) count_d = count_q - CW'(1);
        end
        if (drop_c)               overrun_d = 1'b1;
        else if (bus.clr_overrun) overrun_d = 1'b0;
    end

    // Idle-timeout scheduler: counts baud ticks while data waits untouched
    always_comb begin
        state_d       = state_q;
        tick_d        = tick_q;
        irq_timeout_d = irq_timeout_q;
        case (state_q)
            T_IDLE: begin
                tick_d = '0;
                if (count_d != '0) state_d = T_COUNT;
            end
            T_COUNT: begin
                if (act_c) begin
                    tick_d  = '0;
                    state_d = (count_d != '0) ? T_COUNT : T_IDLE;
                end else if (bus.baud_tick) begin
                    tick_d = tick_q + TW'(1);
                    if (tick_q + TW'(1) == TW'(TIMEOUT_TICKS)) begin
                        irq_timeout_d = 1'b1;
                        state_d       = T_FIRED;
                    end
                end
            end
            T_FIRED: begin
                if (act_c) begin
                    irq_timeout_d = 1'b0;
                    tick_d        = '0;
                    state_d       = (count_d != '0) ? T_COUNT : T_IDLE;
                end
            end
            default: begin
                state_d       = T_IDLE;
                tick_d        = '0;
                irq_timeout_d = 1'b0;
            end
        endcase
    end

    // Combined interrupt, registered one cycle behind its sources
    always_comb begin
        irq_d = (thr_hit_c & bus.irq_en[0]) |
                (irq_timeout_q & bus.irq_en[1]) |
                (overrun_q & bus.irq_en[2]);
    end

    // Control and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overrun_q     <= 1'b0;
            irq_timeout_q <= 1'b0;
            irq_q         <= 1'b0;
            state_q       <= T_IDLE;
            tick_q        <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overrun_q     <= overrun_d;
            irq_timeout_q <= irq_timeout_d;
            irq_q         <= irq_d;
            state_q       <= state_d;
            tick_q        <= tick_d;
        end
    end

    // Character storage, {parity_error, rx_data}; contents survive reset
    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr_q] <= {bus.parity_error, bus.rx_data};
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a queue-based reference model checked every cycle.
module tb_uart_rx_ctrl;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned TO    = 40;

    logic clk;
    logic rst_n;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    bit   chk_en   = 0;

    // Reference model state
    logic [8:0] mq [$];
    bit         m_ovr;
    bit         m_tf;
    bit         m_irq;
    int         m_idle;

    uart_rx_ctrl_if #(.AW(AW)) bus ();

    uart_rx_ctrl #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT_TICKS(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovr  = 0;
        m_tf   = 0;
        m_irq  = 0;
        m_idle = 0;
    endtask

    // Advance the model by one clock from the inputs present at the edge
    task automatic model_step();
        int n       = mq.size();
        bit pop_ok  = bus.rd_en && (n > 0);
        bit push_ok = bus.rx_done && bus.rx_en && ((n < DEPTH) || pop_ok);
        bit drop    = bus.rx_done && bus.rx_en && (n == DEPTH) && !bus.rd_en;
        bit thr     = (bus.thresh != 0) && (n >= int'(bus.thresh));
        m_irq = (thr && bus.irq_en[0]) || (m_tf && bus.irq_en[1]) || (m_ovr && bus.irq_en[2]);
        if (bus.flush) begin
            mq.delete();
        end else begin
            if (pop_ok)  void'(mq.pop_front());
            if (push_ok) mq.push_back({bus.parity_error, bus.rx_data});
        end
        if (drop && !bus.flush)   m_ovr = 1;
        else if (bus.clr_overrun) m_ovr = 0;
        if (bus.flush || push_ok || pop_ok) begin
            m_idle = 0;
            m_tf   = 0;
        end else if (mq.size() == 0) begin
            m_idle = 0;
        end else if (bus.baud_tick && !m_tf) begin
            m_idle++;
            if (m_idle == TO) m_tf = 1;
        end
    endtask

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            logic [8:0] head;
            int         n;
            n    = mq.size();
            head = (n > 0) ? mq[0] : 9'h000;
            check("cmp_rd_data", 32'(bus.rd_data), 32'(head[7:0]));
            check("cmp_rd_perr", 32'(bus.rd_perr), 32'(head[8]));
            check("cmp_count", 32'(bus.count), 32'(n));
            check("cmp_empty", 32'(bus.empty), 32'(n == 0));
            check("cmp_full", 32'(bus.full), 32'(n == DEPTH));
            check("cmp_overrun", 32'(bus.overrun), 32'(m_ovr));
            check("cmp_irq_timeout", 32'(bus.irq_timeout), 32'(m_tf));
            check("cmp_irq", 32'(bus.irq), 32'(m_irq));
        end
    end

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        bus.rx_done     = 1'b0;
        bus.rd_en       = 1'b0;
        bus.flush       = 1'b0;
        bus.clr_overrun = 1'b0;
        bus.baud_tick   = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input logic pe);
        bus.rx_done      = 1'b1;
        bus.rx_data      = d;
        bus.parity_error = pe;
        step();
    endtask

    task automatic pop();
        bus.rd_en = 1'b1;
        step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.baud_tick = 1'b1;
            step();
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.baud_tick    = 1'b0;
        bus.rx_en        = 1'b1;
        bus.rx_done      = 1'b0;
        bus.rx_data      = 8'h00;
        bus.parity_error = 1'b0;
        bus.rd_en        = 1'b0;
        bus.flush        = 1'b0;
        bus.clr_overrun  = 1'b0;
        bus.thresh       = '0;
        bus.irq_en       = 3'b000;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_empty", 32'(bus.empty), 32'd1);
        check("reset_count", 32'(bus.count), 32'd0);
        check("reset_rd_data", 32'(bus.rd_data), 32'd0);
        chk_en = 1;

        // Basic order and parity flags
        push(8'h41, 1'b0);
        push(8'h42, 1'b1);
        push(8'h43, 1'b0);
        check("t1_head0", 32'({bus.rd_perr, bus.rd_data}), 32'h041);
        check("t1_count3", 32'(bus.count), 32'd3);
        pop();
        check("t1_head1", 32'({bus.rd_perr, bus.rd_data}), 32'h142);
        pop();
        check("t1_head2", 32'({bus.rd_perr, bus.rd_data}), 32'h043);
        pop();
        check("t1_empty", 32'(bus.empty), 32'd1);
        check("t1_count0", 32'(bus.count), 32'd0);
        pop();
        check("t1_no_underflow", 32'(bus.count), 32'd0);

        // Fill, overrun, push-with-pop on full
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i), 1'(i % 2));
        check("t2_full", 32'(bus.full), 32'd1);
        check("t2_no_ovr_yet", 32'(bus.overrun), 32'd0);
        push(8'h55, 1'b0);
        check("t2_overrun", 32'(bus.overrun), 32'd1);
        check("t2_count16", 32'(bus.count), 32'd16);
        bus.rd_en = 1'b1;
        push(8'h66, 1'b1);
        check("t2_pushpop_count", 32'(bus.count), 32'd16);
        check("t2_head_after", 32'(bus.rd_data), 32'h11);
        for (int i = 0; i < 15; i++) pop();
        check("t2_last_66", 32'({bus.rd_perr, bus.rd_data}), 32'h166);
        check("t2_count1", 32'(bus.count), 32'd1);
        pop();
        check("t2_drained", 32'(bus.empty), 32'd1);

        // Flush with simultaneous character, overrun survives until cleared
        for (int i = 0; i < 5; i++) push(8'(8'h20 + i), 1'b0);
        bus.flush = 1'b1;
        push(8'h77, 1'b0);
        check("t3_flush_count", 32'(bus.count), 32'd0);
        check("t3_flush_empty", 32'(bus.empty), 32'd1);
        check("t3_ovr_kept", 32'(bus.overrun), 32'd1);
        bus.clr_overrun = 1'b1;
        step();
        check("t3_ovr_clr", 32'(bus.overrun), 32'd0);
        bus.rx_en = 1'b0;
        push(8'h88, 1'b0);
        check("t3_rx_en_off", 32'(bus.count), 32'd0);
        bus.rx_en = 1'b1;

        // Threshold interrupt
        bus.thresh = 5'd4;
        bus.irq_en = 3'b001;
        for (int i = 0; i < 3; i++) push(8'(8'h30 + i), 1'b0);
        check("t4_irq_below", 32'(bus.irq), 32'd0);
        push(8'h33, 1'b0);
        check("t4_count4", 32'(bus.count), 32'd4);
        check("t4_irq_lag", 32'(bus.irq), 32'd0);
        step();
        check("t4_irq_set", 32'(bus.irq), 32'd1);
        pop();
        check("t4_irq_hold", 32'(bus.irq), 32'd1);
        step();
        check("t4_irq_clr", 32'(bus.irq), 32'd0);
        for (int i = 0; i < 3; i++) pop();
        bus.thresh = 5'd0;
        for (int i = 0; i < 5; i++) push(8'(8'h40 + i), 1'b0);
        step();
        check("t4_thresh0", 32'(bus.irq), 32'd0);
        for (int i = 0; i < 5; i++) pop();

        // Idle timeout
        bus.irq_en = 3'b010;
        push(8'h5A, 1'b0);
        ticks(39);
        check("t5_not_yet", 32'(bus.irq_timeout), 32'd0);
        ticks(1);
        check("t5_fired", 32'(bus.irq_timeout), 32'd1);
        check("t5_irq_lag", 32'(bus.irq), 32'd0);
        ticks(3);
        check("t5_irq_set", 32'(bus.irq), 32'd1);
        pop();
        check("t5_to_clr", 32'(bus.irq_timeout), 32'd0);
        step();
        check("t5_irq_clr", 32'(bus.irq), 32'd0);
        ticks(50);
        check("t5_idle_empty", 32'(bus.irq_timeout), 32'd0);

        // Asynchronous reset mid-fill
        bus.thresh = 5'd4;
        bus.irq_en = 3'b001;
        for (int i = 0; i < 7; i++) push(8'(8'h60 + i), 1'b1);
        step();
        check("t6_pre_count", 32'(bus.count), 32'd7);
        check("t6_pre_irq", 32'(bus.irq), 32'd1);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_rst_count", 32'(bus.count), 32'd0);
        check("t6_rst_empty", 32'(bus.empty), 32'd1);
        check("t6_rst_irq", 32'(bus.irq), 32'd0);
        check("t6_rst_rd", 32'({bus.rd_perr, bus.rd_data}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        push(8'h99, 1'b0);
        check("t6_after_rst", 32'({bus.count, bus.rd_data}), 32'h199);
        pop();
        step();

        chk_en = 0;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side controller between the UART receiver's character outputs (rx_data/rx_done/parity_error) and the APB register file. It accepts each completed character and buffers it, together with its parity-error flag, in a first-word-fall-through FIFO. It also tracks overrun, runs a baud-tick-based idle-timeout scheduler, and generates a maskable interrupt for the APB side.

Parameters:
DEPTH, 16, FIFO entries; must be a power of two, minimum 2.
AW, 4, pointer width; must equal log2(DEPTH).
TIMEOUT_TICKS, 40, baud_tick count with no FIFO activity before a timeout is flagged (4 characters at 10 bits). Valid range 1..65535.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
baud_tick  input  1  one-cycle bit-rate strobe, shared with the receiver
rx_en  input  1  receive enable; when 0, rx_done is ignored
rx_done  input  1  one-cycle pulse marking a completed character
rx_data  input  8  character presented with rx_done
parity_error  input  1  parity flag presented with rx_done
rd_en  input  1  APB pop strobe, one cycle per pop
flush  input  1  synchronous FIFO clear
clr_overrun  input  1  clears the overrun sticky flag
thresh  input  AW+1  fill level for the threshold interrupt; 0 disables it
irq_en  input  3  interrupt enables: [0] threshold, [1] timeout, [2] overrun
rd_data  output  8  data of the head entry (FWFT)
rd_perr  output  1  parity flag of the head entry
empty  output  1  FIFO empty
full  output  1  FIFO full
count  output  AW+1  number of entries, 0..DEPTH
overrun  output  1  sticky: a character was dropped
irq_timeout  output  1  sticky idle-timeout flag
irq  output  1  registered, combined interrupt

Behaviour:
- Reset (rst_n low, asynchronous):
  - Pointers and count = 0; empty = 1; full = 0.
  - overrun, irq_timeout and irq = 0.
  - rd_data = 0 and rd_perr = 0 while empty.
  - Timeout FSM = T_IDLE, tick counter = 0.
  - Entries in the storage array are not reset.
- Storage: DEPTH x 9 bits, laid out as {parity_error, rx_data}. Write pointer and read pointer each wrap modulo DEPTH.
- Push:
  - Condition: rx_done & rx_en & (!full | pop_this_cycle).
  - Full FIFO with a simultaneous rd_en: the push is accepted and count is unchanged.
- Pop:
  - Condition: rd_en & !empty. rd_en while empty is ignored and count does not underflow.
  - rd_data/rd_perr present the head entry combinationally from the array whenever !empty, and show the next entry in the cycle after a pop.
- Simultaneous push and pop on a non-empty FIFO: both pointers advance and count is unchanged. On an empty FIFO only the push takes effect.
- Overrun:
  - rx_done & rx_en & full & !rd_en drops the character and sets overrun on the next edge.
  - overrun stays set until clr_overrun. Setting wins over clr_overrun in the same cycle.
  - flush does not clear overrun.
- Flush:
  - Next edge: pointers = 0, count = 0, irq_timeout = 0, FSM = T_IDLE.
  - flush has priority over any push or pop in the same cycle; that character is discarded and does not count as an overrun.
- Timeout FSM:
  - T_IDLE: the counter is held at 0. Go to T_COUNT when count becomes non-zero.
  - T_COUNT:
    - The counter increments on each baud_tick.
    - Any push or pop resets the counter to 0 and keeps the state in T_COUNT.
    - When the counter reaches TIMEOUT_TICKS, set irq_timeout and go to T_FIRED.
    - If count returns to 0, go back to T_IDLE.
  - T_FIRED: irq_timeout stays 1 and the counter holds. Any pop, push or flush clears irq_timeout and returns to T_COUNT, or to T_IDLE if count is 0 after the operation.
- Threshold condition: thr_hit = (thresh != 0) & (count >= thresh), evaluated on the registered count.
- irq: registered version of (thr_hit & irq_en[0]) | (irq_timeout & irq_en[1]) | (overrun & irq_en[2]). It lags its sources by one cycle.
- rx_en deassertion mid-character has no effect on the FIFO. Only rx_done pulses with rx_en high are stored.
- Reset asserted mid-operation discards all buffered data and every flag immediately.

Test Plan:
- Push 0x41, 0x42, 0x43 (perr 0,1,0), then pop three times -> rd_data/rd_perr sequence 0x41/0, 0x42/1, 0x43/0; empty = 1 afterwards and count = 0.
- Fill 16 entries, push 0x55 with no rd_en -> full = 1, overrun = 1, count = 16, 0x55 absent from the FIFO. Then push 0x66 with rd_en in the same cycle -> accepted, count = 16, 0x66 is the last entry read out.
- thresh = 4, irq_en = 3'b001; push four characters -> irq = 1 one cycle after count reaches 4. Pop once -> irq = 0 one cycle later. With thresh = 0, irq never asserts.
- Push one character, then give 40 baud_ticks with no activity, irq_en = 3'b010 -> irq_timeout = 1 on the 40th tick and irq follows. A pop clears both; FSM returns to T_IDLE.
- Assert flush together with rx_done on a FIFO holding 5 entries -> count = 0, empty = 1, the new character is discarded, an existing overrun remains set. clr_overrun then clears it.
- Assert rst_n low mid-fill with count = 7 and irq high -> all outputs return to their reset values asynchronously, without waiting for a clk edge.
